// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, x0 zeroing,
// stall hold with operand refresh, and flush-to-bubble.
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic [XLEN-1:0]   op1_res, op2_res;
    logic              wb_live, refresh1, refresh2;

    // Decode-side operand resolution and held-operand refresh conditions
    always_comb begin
        wb_live  = wb_we && (wb_rd != 5'd0);
        op1_res  = (id_rs1 == 5'd0) ? '0 : (wb_live && wb_rd == id_rs1) ? wb_data : rd1;
        op2_res  = (id_rs2 == 5'd0) ? '0 : (wb_live && wb_rd == id_rs2) ? wb_data : rd2;
        refresh1 = valid_q && wb_live && (wb_rd == rs1_q);
        refresh2 = valid_q && wb_live && (wb_rd == rs2_q);
    end

    // Next-state selection: flush beats stall, stall beats load
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            op1_d   = '0;
            op2_d   = '0;
            imm_d   = '0;
            ctrl_d  = '0;
        end else if (stall) begin
            op1_d = refresh1 ? wb_data : op1_q;
            op2_d = refresh2 ? wb_data : op2_q;
        end else begin
            valid_d = id_valid;
            pc_d    = id_pc;
            rs1_d   = id_rs1;
            rs2_d   = id_rs2;
            rd_d    = id_rd;
            op1_d   = op1_res;
            op2_d   = op2_res;
            imm_d   = id_imm;
            ctrl_d  = id_ctrl;
        end
    end

    // EX-side state register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_valid = valid_q;
    assign ex_pc    = pc_q;
    assign ex_rs1   = rs1_q;
    assign ex_rs2   = rs2_q;
    assign ex_rd    = rd_q;
    assign ex_op1   = op1_q;
    assign ex_op2   = op2_q;
    assign ex_imm   = imm_q;
    assign ex_ctrl  = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a rule-level model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [15:0] ctrl;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0, wb_we = 1'b0;
    logic [31:0] id_pc = '0, rd1 = '0, rd2 = '0, id_imm = '0, wb_data = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
    logic [15:0] id_ctrl = '0;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] ex_ctrl;

    ex_t exp_s = '0;
    ex_t got;
    int  checks = 0;
    int  fails = 0;

    assign got = '{ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl};

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(16), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .rd1(rd1), .rd2(rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
    );

    // Value an operand must take when an instruction is loaded
    function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf_val);
        if (rs == 0) return 32'h0;
        if (wb_we && wb_rd == rs) return wb_data;
        return rf_val;
    endfunction

    // What the EX slot must hold after the coming edge, from the current inputs
    function automatic ex_t model_next(input ex_t s);
        ex_t n = s;
        if (!rst_n) return '0;
        if (flush) return '0;
        if (stall) begin
            if (s.v && wb_we && wb_rd != 0 && wb_rd == s.rs1) n.op1 = wb_data;
            if (s.v && wb_we && wb_rd != 0 && wb_rd == s.rs2) n.op2 = wb_data;
            return n;
        end
        n.v    = id_valid;
        n.pc   = id_pc;
        n.rs1  = id_rs1;
        n.rs2  = id_rs2;
        n.rd   = id_rd;
        n.op1  = resolve(id_rs1, rd1);
        n.op2  = resolve(id_rs2, rd2);
        n.imm  = id_imm;
        n.ctrl = id_ctrl;
        return n;
    endfunction

    task automatic tick();
        exp_s = model_next(exp_s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic load(input logic [4:0] r1, input logic [31:0] v1, input logic [4:0] r2,
                        input logic [31:0] v2);
        id_valid = 1; id_rs1 = r1; rd1 = v1; id_rs2 = r2; rd2 = v2;
        id_pc = $urandom; id_imm = $urandom; id_rd = 5'($urandom_range(1, 31));
        id_ctrl = 16'($urandom);
    endtask

    task automatic test_reset();
        checks++;
        if (got !== '0) begin fails++; $display("FAIL reset_initial got=%h want=0", got); end
        rst_n = 1; idle();
        load(5'd4, 32'h1234, 5'd8, 32'h5678);
        tick();
        checks++;
        if (got !== exp_s) begin fails++; $display("FAIL reset_preload got=%h want=%h", got, exp_s); end
        #2 rst_n = 0;
        exp_s = '0;
        #1;
        checks++;
        if (got !== '0) begin fails++; $display("FAIL reset_async got=%h want=0", got); end
        tick();
        checks++;
        if (got !== '0) begin fails++; $display("FAIL reset_held got=%h want=0", got); end
        rst_n = 1;
        id_pc = 32'h100; id_valid = 1;
        tick();
        checks++;
        if (ex_pc !== 32'h100 || ex_valid !== 1'b1) begin
            fails++; $display("FAIL reset_first_load got pc=%h v=%b want pc=100 v=1", ex_pc, ex_valid);
        end
        checks++;
        if (got !== exp_s) begin fails++; $display("FAIL reset_first_full got=%h want=%h", got, exp_s); end
    endtask

    task automatic test_plain_load();
        idle();
        load(5'd5, 32'hAAAA0001, 5'd6, 32'h12345678);
        tick();
        checks++;
        if (ex_op1 !== 32'hAAAA0001 || ex_op2 !== 32'h12345678) begin
            fails++; $display("FAIL plain_load got op1=%h op2=%h want AAAA0001 12345678", ex_op1, ex_op2);
        end
        checks++;
        if (got !== exp_s) begin fails++; $display("FAIL plain_full got=%h want=%h", got, exp_s); end
    endtask

    task automatic test_bypass_x0();
        idle();
        load(5'd7, 32'h1, 5'd0, 32'hDEAD);
        wb_we = 1; wb_rd = 7; wb_data = 32'hCAFEF00D;
        tick();
        checks++;
        if (ex_op1 !== 32'hCAFEF00D || ex_op2 !== 32'h0) begin
            fails++; $display("FAIL bypass got op1=%h op2=%h want CAFEF00D 0", ex_op1, ex_op2);
        end
        load(5'd0, 32'h55, 5'd3, 32'h33);
        wb_we = 1; wb_rd = 0; wb_data = 32'h99;
        tick();
        checks++;
        if (ex_op1 !== 32'h0 || ex_op2 !== 32'h33) begin
            fails++; $display("FAIL x0_read got op1=%h op2=%h want 0 33", ex_op1, ex_op2);
        end
        id_valid = 0; id_rs1 = 12; rd1 = 32'h4; wb_rd = 12; wb_data = 32'hBEEF;
        tick();
        checks++;
        if (ex_op1 !== 32'hBEEF || ex_valid !== 1'b0) begin
            fails++; $display("FAIL invalid_bypass got op1=%h v=%b want BEEF 0", ex_op1, ex_valid);
        end
    endtask

    task automatic test_dual_bypass();
        idle();
        load(5'd9, 32'h1, 5'd9, 32'h2);
        wb_we = 1; wb_rd = 9; wb_data = 32'h77;
        tick();
        checks++;
        if (ex_op1 !== 32'h77 || ex_op2 !== 32'h77) begin
            fails++; $display("FAIL dual_bypass got op1=%h op2=%h want 77 77", ex_op1, ex_op2);
        end
    endtask

    task automatic test_stall_refresh();
        ex_t snap;
        idle();
        load(5'd3, 32'h10, 5'd11, 32'h44);
        tick();
        snap = got;
        checks++;
        if (ex_op1 !== 32'h10) begin fails++; $display("FAIL stall_pre got op1=%h want 10", ex_op1); end
        stall = 1;
        load(5'd1, 32'hFFFF, 5'd2, 32'hEEEE);
        for (int c = 0; c < 3; c++) begin
            wb_we = (c == 1); wb_rd = 3; wb_data = 32'h20;
            tick();
        end
        snap.op1 = 32'h20;
        checks++;
        if (got !== snap) begin fails++; $display("FAIL stall_refresh got=%h want=%h", got, snap); end
        idle();
        tick();
        checks++;
        if (got !== exp_s || ex_rs1 !== 5'd1 || ex_op1 !== 32'hFFFF) begin
            fails++; $display("FAIL stall_release got=%h want=%h", got, exp_s);
        end
    endtask

    task automatic test_flush_vs_stall();
        idle();
        load(5'd3, 32'h10, 5'd4, 32'h11);
        tick();
        stall = 1; flush = 1;
        tick();
        checks++;
        if (got !== '0) begin fails++; $display("FAIL flush_over_stall got=%h want=0", got); end
        flush = 0; wb_we = 1; wb_rd = 3; wb_data = 32'h5A5A;
        tick();
        checks++;
        if (ex_op1 !== 32'h0 || ex_valid !== 1'b0) begin
            fails++; $display("FAIL no_refresh_bubble got op1=%h v=%b want 0 0", ex_op1, ex_valid);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = 1'($urandom);
            id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom); rd1 = $urandom; rd2 = $urandom;
            wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            tick();
            checks++;
            if (got !== exp_s) begin
                fails++;
                if (bad++ < 5) $display("FAIL random cyc=%0d got=%h want=%h", c, got, exp_s);
            end
        end
    endtask

    initial begin
        idle();
        repeat (2) tick();
        test_reset();
        test_plain_load();
        test_bypass_x0();
        test_dual_bypass();
        test_stall_refresh();
        test_flush_vs_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode/register-file read and execute in the RV32I core.
- Latches the two register-file read operands, immediate, PC, register indices and control bundle for the EX stage.
- Performs same-cycle write-back bypass, because the register file writes on the clock edge and reads combinationally; also forces x0 reads to zero.
- Supports stall (hold), flush (bubble insert) and in-hold operand refresh from write-back.

Parameters:
CTRL_W, 16, width of the opaque decoded-control bundle passed to EX
XLEN, 32, datapath width; only 32 is supported

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all EX-side registers this cycle
flush  in  1  replace EX contents with a bubble this cycle
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  PC of the decode instruction
id_rs1  in  5  source register 1 index (drives register-file A1)
id_rs2  in  5  source register 2 index (drives register-file A2)
id_rd  in  5  destination register index
rd1  in  XLEN  register-file RD1 for id_rs1
rd2  in  XLEN  register-file RD2 for id_rs2
id_imm  in  XLEN  sign-extended immediate
id_ctrl  in  CTRL_W  decoded control bundle
wb_we  in  1  write-back write enable (same signal as register-file WE3)
wb_rd  in  5  write-back destination (register-file A3)
wb_data  in  XLEN  write-back data (register-file WD3)
ex_valid  out  1  EX slot holds a real instruction
ex_pc  out  XLEN  latched PC
ex_rs1  out  5  latched rs1 index
ex_rs2  out  5  latched rs2 index
ex_rd  out  5  latched rd index
ex_op1  out  XLEN  resolved operand 1
ex_op2  out  XLEN  resolved operand 2
ex_imm  out  XLEN  latched immediate
ex_ctrl  out  CTRL_W  latched control bundle

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 immediately and stay at 0 while rst_n is low.
  - The first capture happens on the first rising edge after rst_n rises.
- Per-edge priority is reset > flush > stall > load.
- Load (no flush, no stall), latency 1 cycle:
  - Every ex_* register takes its id_* counterpart.
  - ex_valid takes id_valid.
- Operand resolution on load, for opN with source rsN:
  - if rsN == 0, opN = 0 (the register file does not protect x0);
  - else if wb_we && wb_rd == rsN, opN = wb_data (bypass of the write landing on this same edge);
  - else opN = rdN.
  - Resolution is evaluated independently for op1 and op2; both may bypass in the same cycle.
- Bypass condition details:
  - wb_we with wb_rd == 0 never bypasses.
  - The bypass condition does not depend on id_valid. An invalid slot still latches the resolved values but is marked ex_valid = 0.
- Flush:
  - ex_valid = 0, ex_ctrl = 0, ex_rd = 0, ex_rs1 = 0, ex_rs2 = 0.
  - ex_pc, ex_op1, ex_op2 and ex_imm are also cleared to 0, giving a deterministic bubble.
  - Flush overrides a simultaneous stall.
- Stall (no flush):
  - All fields hold, except the operand refresh below.
  - Refresh: if ex_valid && wb_we && wb_rd != 0 && wb_rd == ex_rs1, ex_op1 takes wb_data. The same rule applies to ex_op2 with ex_rs2.
  - This keeps held operands coherent with register-file writes made during the stall.
  - With ex_valid = 0, no refresh occurs.
- Multi-cycle stall: the state is held indefinitely and refresh applies on every stalled edge.
- Release: release is the first edge with stall = 0; on that edge the block performs a normal load.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. There is no pending state to restore.
- Outputs are registers only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: drive inputs nonzero and assert rst_n low between edges -> all outputs go to 0 without a clock edge. Release reset, load id_pc=0x100, id_valid=1 -> next edge ex_pc=0x100, ex_valid=1.
- Plain load: id_rs1=5, rd1=0xAAAA0001, id_rs2=6, rd2=0x12345678, wb_we=0 -> ex_op1=0xAAAA0001, ex_op2=0x12345678 after 1 edge.
- Bypass and x0: id_rs1=7, id_rs2=0, rd1=0x1, rd2=0xDEAD, wb_we=1, wb_rd=7, wb_data=0xCAFEF00D -> ex_op1=0xCAFEF00D, ex_op2=0. Repeat with wb_rd=0, id_rs1=0, rd1=0x55 -> ex_op1=0.
- Dual bypass: id_rs1=id_rs2=9, wb_we=1, wb_rd=9, wb_data=0x77 -> ex_op1=ex_op2=0x77.
- Stall with refresh: load rs1=3 (op1=0x10), then stall=1 for 3 cycles with wb_we=1, wb_rd=3, wb_data=0x20 on cycle 2 -> ex_op1=0x20 and all other fields unchanged. Release stall -> next decode loads normally.
- Flush vs stall: stall=1 and flush=1 on the same edge with ex_valid=1 -> ex_valid=0, ex_ctrl=0, ex_rd=0. On the next edge with stall=1 and wb_rd matching the old rs1 -> no refresh, ex_op1 stays 0.
